trace_packet_decoder: RTL and testbench



---
 rtl/trace_pkg.sv | 39 +++
 rtl/trace_byte_framer.sv | 87 ++++++++
 rtl/trace_packet_decoder.sv | 119 +++++++++++
 tb/tb_trace_packet_decoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the trace packet receive path.
//
// Contents:
//   pkt_type_e    packet type field encoding (ADDR / READ / WRITE / TIME)
//   bit positions of the fields inside the reassembled 28-bit packet word
//   START_BIT     byte bit that flags byte 0 of a packet
//   pkt_type()    helper that extracts the type field from a packet word
package trace_pkg;

  typedef enum logic [1:0] {
    PKT_ADDR  = 2'b00,
    PKT_READ  = 2'b01,
    PKT_WRITE = 2'b10,
    PKT_TIME  = 2'b11
  } pkt_type_e;

  localparam int START_BIT     = 7;
  localparam int BYTES_PER_PKT = 4;
  localparam int BITS_PER_BYTE = 7;
  localparam int WORD_W        = BYTES_PER_PKT * BITS_PER_BYTE;

  localparam int RSV_MSB   = 27;
  localparam int RSV_LSB   = 25;
  localparam int TYPE_MSB  = 24;
  localparam int TYPE_LSB  = 23;
  localparam int PAYLOAD_W = 23;

  localparam int TS5_MSB  = 22;
  localparam int TS5_LSB  = 18;
  localparam int UBLB_MSB = 17;
  localparam int UBLB_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  function automatic pkt_type_e pkt_type(input logic [WORD_W-1:0] w);
    return pkt_type_e'(w[TYPE_MSB:TYPE_LSB]);
  endfunction

endpackage

// File: rtl/trace_byte_framer.sv
// Byte framer for the 4-byte trace packet stream.
//
// Hunts for the start byte, gathers bytes 1-3 and presents the reassembled
// 28-bit packet word in the same cycle the fourth byte is accepted, so the
// decode stage can register the result directly on that edge.
//
// Ports:
//   mclk, reset_n  clock, asynchronous active-low reset
//   in_data        packet byte
//   in_valid       byte available
//   in_ready       byte accepted when in_valid && in_ready
//   stall          downstream event register full and not draining
//   word           reassembled packet word (valid only with word_valid)
//   word_valid     complete, well-formed packet this cycle
//   frame_err      one-cycle framing error pulse (registered)
//
// state | meaning
// HUNT  | waiting for a byte with the start bit set
// B1    | byte 0 held, expecting byte 1
// B2    | bytes 0-1 held, expecting byte 2
// B3    | bytes 0-2 held, expecting byte 3 (blocked while stall)
module trace_byte_framer
  import trace_pkg::*;
(
  input  logic              mclk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              frame_err
);

  typedef enum logic [1:0] {HUNT, B1, B2, B3} state_e;

  state_e      state;
  logic [20:0] acc;
  logic        accept;
  logic        start;

  // Only the last byte is held back: bytes 0-2 never produce an event,
  // so they can be absorbed while the event register is stalled.
  assign in_ready   = !(stall && (state == B3));
  assign accept     = in_valid && in_ready;
  assign start      = in_data[START_BIT];
  assign word       = {in_data[6:0], acc};
  assign word_valid = accept && (state == B3) && !start &&
                      (word[RSV_MSB:RSV_LSB] == 3'b000);

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HUNT;
      acc       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (accept) begin
        if (start) begin
          // A start byte always opens a new packet; mid-packet it also
          // abandons the partial one.
          acc[6:0]  <= in_data[6:0];
          state     <= B1;
          frame_err <= (state != HUNT);
        end else begin
          case (state)
            HUNT: frame_err <= 1'b1;
            B1: begin
              acc[13:7] <= in_data[6:0];
              state     <= B2;
            end
            B2: begin
              acc[20:14] <= in_data[6:0];
              state      <= B3;
            end
            B3: begin
              state     <= HUNT;
              frame_err <= (word[RSV_MSB:RSV_LSB] != 3'b000);
            end
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/trace_packet_decoder.sv
// Trace packet decoder: receive side of the RAM-tracer packet stream.
//
// Reassembles 4-byte packets, tracks burst address and absolute time, and
// emits one bus event per READ/WRITE packet through a single-entry event
// register with valid/ready handshake.
//
// Ports:
//   mclk, reset_n       clock, asynchronous active-low reset
//   in_data/valid/ready packet byte stream
//   ev_valid/ready      event handshake
//   ev_write            1 = write word, 0 = read word
//   ev_addr, ev_data    word address and data of the event
//   ev_ublb             byte lanes {ub, lb}
//   ev_time             absolute time of the event
//   frame_err           one-cycle framing error pulse
// Optional (macro TRACE_DEC_STATS_EN):
//   stats_clear         synchronous clear of both counters
//   pkt_count           valid packets seen
//   err_count           framing errors seen, saturating
module trace_packet_decoder
  import trace_pkg::*;
#(
  parameter int TIME_W = 32,
  parameter int ADDR_W = 23
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic              ev_write,
  output logic [ADDR_W-1:0] ev_addr,
  output logic [15:0]       ev_data,
  output logic [1:0]        ev_ublb,
  output logic [TIME_W-1:0] ev_time,
  output logic              frame_err
`ifdef TRACE_DEC_STATS_EN
  ,
  input  logic              stats_clear,
  output logic [31:0]       pkt_count,
  output logic [15:0]       err_count
`endif
);

  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              stall;
  logic [ADDR_W-1:0] addr_q;
  logic [TIME_W-1:0] time_q;
  logic [TIME_W-1:0] time_ts;
  logic              unused_rsv;

  assign stall      = ev_valid && !ev_ready;
  assign unused_rsv = ^word[RSV_MSB:RSV_LSB];
  assign time_ts    = time_q + TIME_W'(word[TS5_MSB:TS5_LSB]);

  trace_byte_framer u_framer (
    .mclk       (mclk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .stall      (stall),
    .word       (word),
    .word_valid (word_valid),
    .frame_err  (frame_err)
  );

  // The framer never completes a packet while stall is high, so a load
  // here only happens when the event register is empty or draining.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      time_q   <= '0;
      ev_valid <= 1'b0;
      ev_write <= 1'b0;
      ev_addr  <= '0;
      ev_data  <= '0;
      ev_ublb  <= '0;
      ev_time  <= '0;
    end else begin
      if (ev_valid && ev_ready) ev_valid <= 1'b0;
      if (word_valid) begin
        case (pkt_type(word))
          PKT_ADDR: addr_q <= ADDR_W'(word[PAYLOAD_W-1:0]);
          PKT_READ, PKT_WRITE: begin
            time_q   <= time_ts;
            ev_valid <= 1'b1;
            ev_write <= (pkt_type(word) == PKT_WRITE);
            ev_addr  <= addr_q;
            ev_data  <= word[DATA_MSB:DATA_LSB];
            ev_ublb  <= word[UBLB_MSB:UBLB_LSB];
            ev_time  <= time_ts;
            addr_q   <= addr_q + 1'b1;
          end
          PKT_TIME: time_q <= time_q + TIME_W'(word[PAYLOAD_W-1:0]);
        endcase
      end
    end
  end

`ifdef TRACE_DEC_STATS_EN
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
      err_count <= '0;
    end else if (stats_clear) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (word_valid) pkt_count <= pkt_count + 1'b1;
      if (frame_err && (err_count != 16'hFFFF)) err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_trace_packet_decoder.sv
module tb_trace_packet_decoder;

  localparam int TIME_W = 32;
  localparam int ADDR_W = 23;

  logic              mclk = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              ev_valid;
  logic              ev_ready = 1'b1;
  logic              ev_write;
  logic [ADDR_W-1:0] ev_addr;
  logic [15:0]       ev_data;
  logic [1:0]        ev_ublb;
  logic [TIME_W-1:0] ev_time;
  logic              frame_err;

  trace_packet_decoder #(.TIME_W(TIME_W), .ADDR_W(ADDR_W)) dut (
    .mclk(mclk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_write(ev_write), .ev_addr(ev_addr), .ev_data(ev_data),
    .ev_ublb(ev_ublb), .ev_time(ev_time), .frame_err(frame_err)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        ublb;
    logic [TIME_W-1:0] tm;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  exp_err = 0;
  int  err_seen = 0;
  int  ready_mode = 0;  // 0 always ready, 1 random, 2 never

  // Reference state of the stream, kept as plain integers.
  longint unsigned m_addr = 0;
  longint unsigned m_time = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Packet word from its fields
  function automatic logic [27:0] mk(input int typ, input int payload);
    logic [27:0] w;
    w = '0;
    w[24:23] = 2'(typ);
    w[22:0]  = 23'(payload);
    return w;
  endfunction

  function automatic int rw_payload(input int ts, input int ublb, input int data);
    return (ts << 18) | (ublb << 16) | data;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit acc;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    acc = 1'b0;
    while (!acc) begin
      @(posedge mclk);
      acc = in_ready;
      n++;
      if (n > 2000) begin
        $display("FAIL byte_accept_timeout: got no accept expected accept within 2000 cycles");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench stopped");
      end
    end
    @(negedge mclk);
  endtask

  // Reference model: apply the packet's meaning, then put it on the wire.
  task automatic send_pkt(input logic [27:0] w);
    int typ;
    longint unsigned pl;
    ev_t e;
    typ = int'(w[24:23]);
    pl  = longint'(w[22:0]);
    if (w[27:25] != 0) exp_err++;
    else if (typ == 0) m_addr = pl;
    else if (typ == 3) m_time = (m_time + pl) % (64'd1 << TIME_W);
    else begin
      m_time = (m_time + (pl >> 18)) % (64'd1 << TIME_W);
      e.wr   = (typ == 2);
      e.addr = ADDR_W'(m_addr);
      e.data = 16'(pl & 64'hFFFF);
      e.ublb = 2'((pl >> 16) & 64'h3);
      e.tm   = TIME_W'(m_time);
      exp_q.push_back(e);
      m_addr = (m_addr + 1) % (64'd1 << ADDR_W);
    end
    send_byte({1'b1, w[6:0]});
    send_byte({1'b0, w[13:7]});
    send_byte({1'b0, w[20:14]});
    send_byte({1'b0, w[27:21]});
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || ev_valid) && n < 1000) begin
      @(negedge mclk);
      n++;
    end
    repeat (3) @(negedge mclk);
    check("drain_pending", exp_q.size(), 0);
    check("frame_err_count", err_seen, exp_err);
  endtask

  // ev_ready driver
  initial forever begin
    @(negedge mclk);
    case (ready_mode)
      0: ev_ready = 1'b1;
      1: ev_ready = ($urandom_range(0, 3) != 0);
      default: ev_ready = 1'b0;
    endcase
  end

  // Monitor: pops expected events on each handshake, checks hold stability.
  ev_t prev;
  bit  held = 0;
  always @(posedge mclk) begin
    ev_t cur, e;
    cur = '{ev_write, ev_addr, ev_data, ev_ublb, ev_time};
    if (!reset_n) begin
      held = 0;
    end else begin
      if (frame_err) err_seen++;
      if (held) check("ev_hold_stable", cur, prev);
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: got addr 0x%0h expected no event", ev_addr);
        end else begin
          e = exp_q.pop_front();
          check("ev_write", cur.wr, e.wr);
          check("ev_addr", cur.addr, e.addr);
          check("ev_data", cur.data, e.data);
          check("ev_ublb", cur.ublb, e.ublb);
          check("ev_time", cur.tm, e.tm);
        end
      end
      held = ev_valid && !ev_ready;
      prev = cur;
    end
  end

  initial begin
    logic [27:0] w;
    repeat (3) @(negedge mclk);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ev_addr", ev_addr, 0);
    check("rst_ev_time", ev_time, 0);
    reset_n = 1'b1;
    @(negedge mclk);

    // Basic write and reads
    send_pkt(mk(0, 23'h000100));
    send_pkt(mk(2, rw_payload(3, 3, 16'hBEEF)));
    send_pkt(mk(1, rw_payload(1, 0, 16'h1111)));
    send_pkt(mk(1, rw_payload(1, 2, 16'h2222)));
    // Time advance
    send_pkt(mk(3, 23'h000040));
    send_pkt(mk(1, rw_payload(0, 1, 16'h5A5A)));
    drain();

    // Start flag mid-packet; following packet begins with the 0x80 byte
    send_byte(8'h81);
    send_byte(8'h05);
    exp_err++;
    send_pkt(mk(1, rw_payload(2, 1, 16'h3380)));
    // Stray continuation byte while hunting
    send_byte(8'h12);
    exp_err++;
    send_pkt(mk(2, rw_payload(4, 2, 16'hC0DE)));
    drain();

    // Stalled consumer during a 3-packet burst
    ready_mode = 2;
    fork
      begin
        send_pkt(mk(2, rw_payload(1, 3, 16'hA001)));
        send_pkt(mk(1, rw_payload(2, 0, 16'hA002)));
        send_pkt(mk(2, rw_payload(3, 1, 16'hA003)));
      end
      begin
        repeat (20) @(negedge mclk);
        check("stall_in_ready_low", in_ready, 0);
        check("stall_ev_valid", ev_valid, 1);
        ready_mode = 0;
      end
    join
    drain();

    // Address wrap
    send_pkt(mk(0, 23'h7FFFFF));
    send_pkt(mk(2, rw_payload(1, 3, 16'h0F0F)));
    send_pkt(mk(2, rw_payload(1, 3, 16'hF0F0)));
    drain();

    // Reset mid-packet
    send_byte(8'h81);
    send_byte(8'h22);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mrst_ev_valid", ev_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_ev_addr", ev_addr, 0);
    check("mrst_ev_data", ev_data, 0);
    check("mrst_ev_time", ev_time, 0);
    m_addr = 0;
    m_time = 0;
    @(negedge mclk);
    reset_n = 1'b1;
    @(negedge mclk);
    send_pkt(mk(2, rw_payload(7, 2, 16'h1234)));
    drain();

    // Randomized traffic with random backpressure
    ready_mode = 1;
    for (int i = 0; i < 200; i++) begin
      w = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 23'h7FFFFF)));
      if ($urandom_range(0, 15) == 0) w[27:25] = 3'($urandom_range(1, 7));
      send_pkt(w);
      if ($urandom_range(0, 7) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge mclk);
      end
    end
    ready_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
